// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// link-register placement and the hardwired zero-register address.
package regfile_pkg;

  localparam int unsigned DEF_W     = 32;
  localparam int unsigned DEF_NREG  = 32;
  localparam int unsigned ZERO_ADDR = 0;

  // Link register sits at the top of the array by default.
  function automatic int unsigned link_reg_default(input int unsigned nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight destinations: set on issue, clear on
// writeback/link write, busy lookups for both read ports and a running count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG     = DEF_NREG,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREG),
  localparam int unsigned CW      = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_dest,
  input  logic          clr_a_en,
  input  logic [AW-1:0] clr_a_addr,
  input  logic          clr_b_en,
  input  logic [AW-1:0] clr_b_addr,
  input  logic [AW-1:0] rr1,
  input  logic [AW-1:0] rr2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [CW-1:0] pend_cnt
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_ADDR);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] pend_nxt;
  logic            rise;
  logic            fall_a;
  logic            fall_b;
  logic [CW-1:0]   cnt_nxt;

  // Set beats clear so a new producer supersedes the retiring one.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_en)   set_vec[iss_dest]   = 1'b1;
    if (clr_a_en) clr_vec[clr_a_addr] = 1'b1;
    if (clr_b_en) clr_vec[clr_b_addr] = 1'b1;
    if (ZERO_REG) set_vec[ZERO_A]     = 1'b0;
    pend_nxt = (pend & ~clr_vec) | set_vec;
  end

  // Incremental count: one possible set, two possible (deduplicated) clears.
  always_comb begin
    rise    = iss_en && set_vec[iss_dest] && !pend[iss_dest];
    fall_a  = clr_a_en && pend[clr_a_addr] && !set_vec[clr_a_addr];
    fall_b  = clr_b_en && pend[clr_b_addr] && !set_vec[clr_b_addr] &&
              !(clr_a_en && (clr_a_addr == clr_b_addr));
    cnt_nxt = pend_cnt + CW'(rise) - CW'(fall_a) - CW'(fall_b);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // A register retiring this cycle is already visible through the bypass.
  always_comb begin
    rs1_busy = pend[rr1] && !(ZERO_REG && (rr1 == ZERO_A)) && !(BYPASS && clr_vec[rr1]);
    rs2_busy = pend[rr2] && !(ZERO_REG && (rr2 == ZERO_A)) && !(BYPASS && clr_vec[rr2]);
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two async read ports, a writeback port, a dedicated link
// write port, optional write-to-read bypass and a RAW-hazard scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned W        = DEF_W,
  parameter int unsigned NREG     = DEF_NREG,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned LINK_REG = link_reg_default(NREG),
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] rr1_in,
  input  logic [AW-1:0] rr2_in,
  output logic [W-1:0]  rdata1_out,
  output logic [W-1:0]  rdata2_out,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          link_en,
  input  logic [W-1:0]  link_data,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_dest,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [AW:0]   pend_cnt,
  output logic          wr_collide
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_ADDR);

  logic [W-1:0] mem [NREG];
  logic         collide_c;
  logic         wb_eff;
  logic         link_eff;

  // Main port wins a same-address fight with the link port.
  always_comb begin
    collide_c = link_en && wb_en && (wb_addr == LINK_A);
    wb_eff    = wb_en && !(ZERO_REG && (wb_addr == ZERO_A));
    link_eff  = link_en && !collide_c && !(ZERO_REG && (LINK_A == ZERO_A));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (wb_eff && (wb_addr == AW'(i)))        mem[i] <= wb_data;
        else if (link_eff && (LINK_A == AW'(i)))  mem[i] <= link_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wr_collide <= 1'b0;
    else          wr_collide <= collide_c;
  end

  // Zero register overrides everything, then bypass, then stored value.
  function automatic logic [W-1:0] read_port(input logic [AW-1:0] addr);
    logic [W-1:0] val;
    val = mem[addr];
    if (BYPASS) begin
      if (wb_eff && (wb_addr == addr))        val = wb_data;
      else if (link_eff && (LINK_A == addr))  val = link_data;
    end
    if (ZERO_REG && (addr == ZERO_A)) val = '0;
    return val;
  endfunction

  always_comb rdata1_out = read_port(rr1_in);
  always_comb rdata2_out = read_port(rr2_in);

  regfile_scoreboard #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .iss_en     (iss_en),
    .iss_dest   (iss_dest),
    .clr_a_en   (wb_en),
    .clr_a_addr (wb_addr),
    .clr_b_en   (link_eff),
    .clr_b_addr (LINK_A),
    .rr1        (rr1_in),
    .rr2        (rr2_in),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .pend_cnt   (pend_cnt)
  );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the datapath register file: W-bit x NREG-entry array, two asynchronous read ports, one main writeback port and one dedicated link-register write port.
- Adds an optional write-to-read bypass and a per-register pending scoreboard, which let the pipelined datapath detect RAW hazards on in-flight destinations.
- Sits between decode (reads, issue), writeback (writes) and the hazard unit (busy flags).

Parameters:
- W, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 4.
- AW, $clog2(NREG), register address width (derived; do not override).
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and issues.
- LINK_REG, NREG-1, target register of the link write port.
- BYPASS, 1, 1 = a read of the register being written this cycle returns the new data.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rr1_in  in  AW  read address, port 1.
- rr2_in  in  AW  read address, port 2.
- rdata1_out  out  W  read data, port 1 (combinational).
- rdata2_out  out  W  read data, port 2 (combinational).
- wb_en  in  1  main writeback enable.
- wb_addr  in  AW  main writeback address.
- wb_data  in  W  main writeback data.
- link_en  in  1  link write enable (jal); writes LINK_REG.
- link_data  in  W  link write data.
- iss_en  in  1  an instruction with a destination issues this cycle.
- iss_dest  in  AW  destination register of the issuing instruction.
- rs1_busy  out  1  rr1_in has an outstanding producer.
- rs2_busy  out  1  rr2_in has an outstanding producer.
- pend_cnt  out  AW+1  number of pending registers.
- wr_collide  out  1  registered one-cycle pulse: link write dropped.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - all array entries = 0.
  - all pending bits = 0.
  - pend_cnt = 0 and wr_collide = 0.
  - read outputs therefore read 0.
  - Deassertion is used synchronously downstream; no cycle after reset requires special handling.
- Writes (posedge clock):
  - wb_en writes wb_data to array[wb_addr].
  - link_en writes link_data to array[LINK_REG].
  - wb_en and link_en both set with wb_addr == LINK_REG: the main port wins, the link write is dropped, and wr_collide = 1 on the next cycle.
  - Both enables set with different addresses: both writes occur.
  - With ZERO_REG = 1, writes to address 0 are discarded and array[0] stays 0.
- Reads (combinational, zero latency):
  - rdataN_out = array[rrN_in].
  - ZERO_REG = 1 and rrN_in == 0: output is 0 regardless of bypass.
  - BYPASS = 1: if wb_en and wb_addr == rrN_in (and the address is not a discarded zero-register write), output wb_data.
  - BYPASS = 1: else if a link write is effective and rrN_in == LINK_REG, output link_data.
  - BYPASS = 0: outputs show the old value until the next edge.
- Scoreboard, pending bit per register (posedge clock):
  - Set: iss_en sets pending[iss_dest].
  - Clear: wb_en clears pending[wb_addr]; an effective link write clears pending[LINK_REG].
  - Same register set and cleared in one cycle: set wins (new producer supersedes).
  - Register 0 is never pending when ZERO_REG = 1.
  - Issue to a register already pending: the bit stays 1, no error.
  - Clear of a non-pending register: no effect.
- Busy flags (combinational):
  - rsN_busy = pending[rrN_in], masked to 0 for address 0 when ZERO_REG = 1.
  - With BYPASS = 1, also masked to 0 when that register is cleared this same cycle.
- pend_cnt:
  - Updated incrementally each cycle as +1 per 0->1 transition and -1 per 1->0 transition; at most one set and two clears per cycle.
  - Must always equal the popcount of the pending vector.
  - Never exceeds NREG, or NREG-1 with ZERO_REG = 1.

Decomposition:
- A shared package (regfile_pkg) holds the default W/NREG, the LINK_REG default, and the zero-register address constant.
- One sub-module is natural: regfile_scoreboard, containing the pending vector, the set/clear priority logic, the busy lookups and pend_cnt.
- The top level holds the array, the write arbitration and the bypass muxes.

Test Plan:
1. Reset mid-operation:
   - Stimulus: write 0xDEADBEEF to r5, issue r5, then pulse reset_n low between edges.
   - Required: rdata of r5 = 0 immediately, rs1_busy = 0, pend_cnt = 0.
2. Bypass:
   - Stimulus: BYPASS = 1, rr1 = 7, wb_en with r7 <- 0x12345678 in the same cycle.
   - Required: rdata1_out = 0x12345678 before the edge.
   - Repeat with BYPASS = 0: rdata1_out = old value 0, then 0x12345678 after the edge.
3. Zero register:
   - Stimulus: wb r0 <- 0xFFFFFFFF and iss_dest = 0.
   - Required: rdata = 0, rs1_busy = 0, pend_cnt unchanged.
4. Link collision:
   - Stimulus: wb_en (r31 <- 0xA) and link_en (link_data 0xB) in the same cycle.
   - Required: r31 = 0xA, wr_collide = 1 for exactly one cycle.
   - Repeat with wb_addr = 3: r3 = 0xA, r31 = 0xB, no collision pulse.
5. Scoreboard set/clear:
   - Issue r4 -> rs1_busy = 1 (rr1 = 4), pend_cnt = 1.
   - In one cycle, wb r4 plus issue r4 -> still busy, pend_cnt = 1.
   - wb r4 alone -> busy = 0 (same cycle with BYPASS = 1), pend_cnt = 0.
6. Fill:
   - Issue r1..r31 on consecutive cycles -> pend_cnt = 31.
   - Writeback all in reverse order -> pend_cnt decrements to 0 with no underflow.
